// File: rtl/mul_add_reconstruct_pkg.sv
// Shared constants for the divider / reconstruct pair: FSM encoding, default
// operand width and the field positions inside the packed values bus.
package mul_add_reconstruct_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Field index inside values; multiply by WIDTH for the LSB position.
  localparam int QUOT_FIELD = 2;
  localparam int DIV_FIELD  = 1;
  localparam int REM_FIELD  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TEST  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

endpackage

// File: rtl/mul_add_reconstruct_if.sv
// req/ack bus shared by the divider and its reconstruct partner.
interface mul_add_reconstruct_if #(
  parameter int WIDTH = mul_add_reconstruct_pkg::DEFAULT_WIDTH
);
  logic                 req;
  logic [3*WIDTH-1:0]   values;
  logic                 ack;
  logic                 busy;
  logic                 err;
  logic [2*WIDTH-1:0]   result;

  modport master (output req, values, input ack, busy, err, result);
  modport slave  (input req, values, output ack, busy, err, result);
endinterface

// File: rtl/mul_add_reconstruct.sv
// Shift-and-add unit rebuilding quotient*divisor + remainder, flagging tuples
// that no valid division could have produced.
module mul_add_reconstruct
  import mul_add_reconstruct_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mul_add_reconstruct_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               state_r;
  state_e               state_s;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        cnt_r;
  logic                 errflag_r;
  logic                 ack_r;
  logic                 busy_r;
  logic                 err_r;
  logic [2*WIDTH-1:0]   result_r;

  logic [WIDTH-1:0]     quot_s;
  logic [WIDTH-1:0]     div_s;
  logic [WIDTH-1:0]     rem_s;
  logic                 last_iter_s;

  assign quot_s      = bus.values[QUOT_FIELD*WIDTH +: WIDTH];
  assign div_s       = bus.values[DIV_FIELD*WIDTH  +: WIDTH];
  assign rem_s       = bus.values[REM_FIELD*WIDTH  +: WIDTH];
  assign last_iter_s = (cnt_r == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; always WIDTH iterations, no early exit on a zero multiplier.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req) state_s = ST_TEST;
        else         state_s = ST_IDLE;
      end
      ST_TEST: begin
        if (mplier_r[0]) state_s = ST_ADD;
        else             state_s = ST_SHIFT;
      end
      ST_ADD:  state_s = ST_SHIFT;
      ST_SHIFT: begin
        if (last_iter_s) state_s = ST_DONE;
        else             state_s = ST_TEST;
      end
      ST_DONE: state_s = ST_HOLD;
      ST_HOLD: begin
        if (bus.req) state_s = ST_HOLD;
        else         state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, accumulate, shift, and publish on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r     <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      cnt_r     <= '0;
      errflag_r <= 1'b0;
      err_r     <= 1'b0;
      result_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req) begin
            acc_r     <= {{WIDTH{1'b0}}, rem_s};
            mcand_r   <= {{WIDTH{1'b0}}, div_s};
            mplier_r  <= quot_s;
            cnt_r     <= '0;
            errflag_r <= (div_s == '0) | (rem_s >= div_s);
          end
        end
        ST_ADD: begin
          acc_r <= acc_r + mcand_r;
        end
        ST_SHIFT: begin
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
        end
        ST_DONE: begin
          result_r <= acc_r;
          err_r    <= errflag_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Handshake outputs; busy tracks the state being entered so it is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      ack_r  <= (state_r == ST_DONE);
      busy_r <= (state_s != ST_IDLE);
    end
  end

  assign bus.ack    = ack_r;
  assign bus.busy   = busy_r;
  assign bus.err    = err_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_mul_add_reconstruct.sv
// Directed and randomized bench for mul_add_reconstruct against an arithmetic model.
module tb_mul_add_reconstruct;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mul_add_reconstruct_if #(.WIDTH(W)) bus ();
  mul_add_reconstruct #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_result(input logic [7:0] q, d, r);
    int v;
    v = int'(q) * int'(d) + int'(r);
    return v[15:0];
  endfunction

  function automatic logic model_err(input logic [7:0] d, r);
    return (d == 8'd0) || (r >= d);
  endfunction

  function automatic int model_lat(input logic [7:0] q);
    return 2 * W + $countones(q) + 1;
  endfunction

  // One full transaction; disturb scrambles values and pulses req low while busy.
  task automatic run_op(input string tag, input logic [7:0] q, d, r, input bit disturb);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.values = {q, d, r};
    bus.req = 1'b1;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (disturb && n == 3) begin
        bus.values = ~bus.values;
        bus.req = 1'b0;
      end
      if (disturb && n == 5) bus.req = 1'b1;
      seen = bus.ack;
    end
    check({tag, ":ack_seen"}, 32'(seen), 32'd1);
    check({tag, ":latency"}, 32'(n - 1), 32'(model_lat(q)));
    check({tag, ":result"}, 32'(bus.result), 32'(model_result(q, d, r)));
    check({tag, ":err"}, 32'(bus.err), 32'(model_err(d, r)));
    check({tag, ":busy_at_ack"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({tag, ":ack_one_cycle"}, 32'(bus.ack), 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    check({tag, ":busy_drop"}, 32'(bus.busy), 32'd0);
    check({tag, ":result_held"}, 32'(bus.result), 32'(model_result(q, d, r)));
  endtask

  initial begin
    int acks;
    logic [7:0] rq, rd, rr;

    bus.req = 1'b0;
    bus.values = '0;
    #2 reset_n = 1'b0;
    #1;
    check("reset:ack", 32'(bus.ack), 32'd0);
    check("reset:busy", 32'(bus.busy), 32'd0);
    check("reset:err", 32'(bus.err), 32'd0);
    check("reset:result", 32'(bus.result), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op("t1", 8'h0C, 8'h05, 8'h03, 1'b0);
    run_op("t2", 8'hFF, 8'hFF, 8'hFE, 1'b0);
    run_op("t3", 8'h12, 8'h00, 8'h07, 1'b0);
    run_op("t4a", 8'h01, 8'h04, 8'h04, 1'b0);
    run_op("t4b", 8'h00, 8'h10, 8'h0F, 1'b0);

    // Continuously held req must yield exactly one ack.
    @(negedge clk);
    bus.values = {8'h0A, 8'h03, 8'h01};
    bus.req = 1'b1;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ack) acks++;
    end
    check("t5:held_acks", 32'(acks), 32'd1);
    check("t5:held_result", 32'(bus.result), 32'(model_result(8'h0A, 8'h03, 8'h01)));
    check("t5:held_busy", 32'(bus.busy), 32'd1);
    bus.req = 1'b0;
    @(negedge clk);
    run_op("t5b", 8'h02, 8'h03, 8'h01, 1'b1);

    run_op("pre_rst", 8'h05, 8'h00, 8'h09, 1'b0);

    // Reset mid-operation clears everything asynchronously, no ack afterwards.
    @(negedge clk);
    bus.values = {8'hFF, 8'h01, 8'h00};
    bus.req = 1'b1;
    repeat (8) @(negedge clk);
    check("t6:busy_before", 32'(bus.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6:ack", 32'(bus.ack), 32'd0);
    check("t6:busy", 32'(bus.busy), 32'd0);
    check("t6:err", 32'(bus.err), 32'd0);
    check("t6:result", 32'(bus.result), 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.ack) acks++;
    end
    check("t6:no_ack", 32'(acks), 32'd0);
    check("t6:idle", 32'(bus.busy), 32'd0);
    run_op("t6b", 8'h03, 8'h07, 8'h02, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rq = 8'($urandom_range(0, 255));
      rd = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0 || rd == 8'd0) rr = 8'($urandom_range(0, 255));
      else rr = 8'($urandom_range(0, int'(rd) - 1));
      run_op($sformatf("rand%0d", i), rq, rd, rr, (i % 4) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
